// File: rtl/vxe_vpu_pkg.sv
// ----------------------------------------------------------------------------
// vxe_vpu_pkg
// Shared VPU widths and the LSU read-request stage record. These are used by
// the read-request arbiter and are meant for reuse by the write-side arbiter.
// ----------------------------------------------------------------------------
package vxe_vpu_pkg;

    localparam int TH_W   = 3;   // thread id width
    localparam int ADDR_W = 37;  // LSU address width
    localparam int DATA_W = 64;  // LSU data width

    // One staged LSU request, as presented on the o_rrq_* port.
    typedef struct packed {
        logic              vld;
        logic [TH_W-1:0]   th;
        logic [ADDR_W-1:0] addr;
        logic              arg;
    } rrq_stage_t;

endpackage : vxe_vpu_pkg

// File: rtl/vxe_rr_pick.sv
// ----------------------------------------------------------------------------
// vxe_rr_pick
// Combinational round-robin picker. The scan starts at the slot after ptr and
// wraps, so the most recently granted slot gets the lowest priority.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index of the most recent grant
//   gnt  out N   one-hot grant (all zero if there is no request)
//   idx  out IW  index of the granted slot
//   any  out 1   at least one request is present
// ----------------------------------------------------------------------------
module vxe_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int slot;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        slot = 0;
        for (int off = 1; off <= N; off++) begin
            slot = (int'(ptr) + off) % N;
            if (!any && req[slot]) begin
                any       = 1'b1;
                gnt[slot] = 1'b1;
                idx       = IW'(slot);
            end
        end
    end

endmodule : vxe_rr_pick

// File: rtl/vxe_vpu_rrq_arb.sv
// ----------------------------------------------------------------------------
// vxe_vpu_rrq_arb
// Round-robin arbiter that shares the LSU read-request port among NTHR vector
// threads. A per-thread credit counter bounds that thread's in-flight reads.
// LSU read responses are routed back to the owning thread by i_rrs_th.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   i_reinit             flush staged request, clear credits and pointer
//   o_busy               staged request pending or any credit non-zero
//   i_rq_vld/addr/arg    per-thread requests (addr of thread t at [t*37 +: 37])
//   o_rq_ack             one-hot grant pulse, request taken this cycle
//   i_rrq_rdy            LSU can accept a read request
//   o_rrq_wr/th/addr/arg staged request towards the LSU
//   i_rrs_vld/th/arg/data LSU read response
//   o_rrs_rd             response pop towards the LSU
//   o_rs_vld/arg/data    response delivered to threads (vld one-hot by thread)
//   i_rs_rd              per-thread response consume
// ----------------------------------------------------------------------------
module vxe_vpu_rrq_arb
    import vxe_vpu_pkg::*;
#(
    parameter int NTHR     = 8,
    parameter int OUT_POW2 = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_reinit,
    output logic                     o_busy,
    input  logic [NTHR-1:0]          i_rq_vld,
    input  logic [NTHR*ADDR_W-1:0]   i_rq_addr,
    input  logic [NTHR-1:0]          i_rq_arg,
    output logic [NTHR-1:0]          o_rq_ack,
    input  logic                     i_rrq_rdy,
    output logic                     o_rrq_wr,
    output logic [TH_W-1:0]          o_rrq_th,
    output logic [ADDR_W-1:0]        o_rrq_addr,
    output logic                     o_rrq_arg,
    input  logic                     i_rrs_vld,
    output logic                     o_rrs_rd,
    input  logic [TH_W-1:0]          i_rrs_th,
    input  logic                     i_rrs_arg,
    input  logic [DATA_W-1:0]        i_rrs_data,
    output logic [NTHR-1:0]          o_rs_vld,
    output logic                     o_rs_arg,
    output logic [DATA_W-1:0]        o_rs_data,
    input  logic [NTHR-1:0]          i_rs_rd
);

    localparam int              CW       = OUT_POW2 + 1;
    localparam logic [CW:0]     CRED_MAX = (CW+1)'(1 << OUT_POW2);

    rrq_stage_t      stg_reg, stg_next;
    logic [TH_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [NTHR-1:0] elig;
    logic [NTHR-1:0] cred_nz;
    logic [NTHR-1:0] pick_gnt;
    logic [TH_W-1:0] pick_idx;
    logic            pick_any;
    logic            rrq_wr;
    logic            ld;
    logic            take;

    // ------------------------------------------------------------------
    // Arbitration and output stage
    // ------------------------------------------------------------------
    assign rrq_wr = stg_reg.vld & i_rrq_rdy & ~i_reinit;
    // Stage may be reloaded in the same cycle it drains: one request per clk.
    assign ld     = ~stg_reg.vld | rrq_wr;
    assign take   = ld & pick_any & ~i_reinit;

    vxe_rr_pick #(
        .N  (NTHR),
        .IW (TH_W)
    ) u_pick (
        .req (elig),
        .ptr (rr_ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        stg_next    = stg_reg;
        rr_ptr_next = rr_ptr_reg;
        if (i_reinit) begin
            stg_next    = '0;
            rr_ptr_next = TH_W'(NTHR - 1);
        end else if (take) begin
            stg_next.vld  = 1'b1;
            stg_next.th   = pick_idx;
            stg_next.addr = i_rq_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            stg_next.arg  = i_rq_arg[pick_idx];
            rr_ptr_next   = pick_idx;
        end else if (ld) begin
            stg_next.vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stg_reg    <= '0;
            rr_ptr_reg <= TH_W'(NTHR - 1);
        end else begin
            stg_reg    <= stg_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign o_rq_ack   = take ? pick_gnt : '0;
    assign o_rrq_wr   = rrq_wr;
    assign o_rrq_th   = stg_reg.th;
    assign o_rrq_addr = stg_reg.addr;
    assign o_rrq_arg  = stg_reg.arg;
    assign o_busy     = stg_reg.vld | (|cred_nz);

    // ------------------------------------------------------------------
    // Response demux (pure pass-through; an in-order LSU stalls on a
    // blocked thread)
    // ------------------------------------------------------------------
    assign o_rrs_rd  = |(o_rs_vld & i_rs_rd);
    assign o_rs_arg  = i_rrs_arg;
    assign o_rs_data = i_rrs_data;

    // ------------------------------------------------------------------
    // Per-thread credit counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NTHR; gi++) begin : g_th
        logic [CW-1:0] cred_reg, cred_next;
        logic          cred_inc, cred_dec;
        logic [CW:0]   inflight;

        assign o_rs_vld[gi] = i_rrs_vld & (i_rrs_th == TH_W'(gi));

        assign cred_inc = rrq_wr & (stg_reg.th == TH_W'(gi));
        assign cred_dec = o_rs_vld[gi] & o_rrs_rd;

        // A staged request for this thread is about to consume a credit, so it
        // counts as in flight; otherwise a thread could be granted once more
        // while its last allowed read sits in the stage.
        assign inflight = {1'b0, cred_reg}
                        + (CW+1)'(stg_reg.vld && (stg_reg.th == TH_W'(gi)));
        assign elig[gi]    = i_rq_vld[gi] & (inflight < CRED_MAX);
        assign cred_nz[gi] = (cred_reg != '0);

        always_comb begin
            cred_next = cred_reg;
            if (i_reinit) begin
                cred_next = '0;
            end else if (cred_inc && !cred_dec) begin
                if ({1'b0, cred_reg} != CRED_MAX)
                    cred_next = cred_reg + 1'b1;
            end else if (cred_dec && !cred_inc) begin
                // Stale responses after a reinit must not wrap below zero.
                if (cred_reg != '0)
                    cred_next = cred_reg - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst)
                cred_reg <= '0;
            else
                cred_reg <= cred_next;
        end
    end

endmodule : vxe_vpu_rrq_arb

// File: tb/tb_vxe_vpu_rrq_arb.sv
// ----------------------------------------------------------------------------
// tb_vxe_vpu_rrq_arb
// Directed bench for the VPU read-request arbiter. Inputs are driven 1 ns
// after the rising edge, outputs sampled 3 ns later (mid-cycle).
// ----------------------------------------------------------------------------
module tb_vxe_vpu_rrq_arb;

    localparam int NTHR = 8;

    logic            clk = 1'b0;
    logic            nrst;
    logic            reinit;
    logic            busy;
    logic [7:0]      rq_vld;
    logic [8*37-1:0] rq_addr;
    logic [7:0]      rq_arg;
    logic [7:0]      rq_ack;
    logic            rrq_rdy;
    logic            rrq_wr;
    logic [2:0]      rrq_th;
    logic [36:0]     rrq_addr;
    logic            rrq_arg;
    logic            rrs_vld;
    logic            rrs_rd;
    logic [2:0]      rrs_th;
    logic            rrs_arg;
    logic [63:0]     rrs_data;
    logic [7:0]      rs_vld;
    logic            rs_arg;
    logic [63:0]     rs_data;
    logic [7:0]      rs_rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vxe_vpu_rrq_arb #(.NTHR(NTHR), .OUT_POW2(2)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_reinit   (reinit),
        .o_busy     (busy),
        .i_rq_vld   (rq_vld),
        .i_rq_addr  (rq_addr),
        .i_rq_arg   (rq_arg),
        .o_rq_ack   (rq_ack),
        .i_rrq_rdy  (rrq_rdy),
        .o_rrq_wr   (rrq_wr),
        .o_rrq_th   (rrq_th),
        .o_rrq_addr (rrq_addr),
        .o_rrq_arg  (rrq_arg),
        .i_rrs_vld  (rrs_vld),
        .o_rrs_rd   (rrs_rd),
        .i_rrs_th   (rrs_th),
        .i_rrs_arg  (rrs_arg),
        .i_rrs_data (rrs_data),
        .o_rs_vld   (rs_vld),
        .o_rs_arg   (rs_arg),
        .o_rs_data  (rs_data),
        .i_rs_rd    (rs_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int t, input logic [36:0] a);
        rq_addr[t*37 +: 37] = a;
    endtask

    // Return one response per listed thread, popped immediately.
    task automatic drain(input string tag, input int th, input int n);
        for (int i = 0; i < n; i++) begin
            rrs_vld = 1'b1;
            rrs_th  = 3'(th);
            rs_rd   = 8'hff;
            #3;
            chk(tag, rrs_rd, 1);
            tick();
        end
        rrs_vld = 1'b0;
        rs_rd   = 8'h00;
    endtask

    int   acks;
    int   seq3[3];
    int   cnt[8];
    int   nack;
    logic prev_wr;
    logic [2:0] prev_th;
    logic drop;
    logic [7:0] drop_mask;
    int   n_ack_th[8];

    initial begin
        nrst = 1'b0; reinit = 1'b0; rq_vld = '0; rq_addr = '0; rq_arg = '0;
        rrq_rdy = 1'b0; rrs_vld = 1'b0; rrs_th = '0; rrs_arg = 1'b0;
        rrs_data = '0; rs_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr",   rrq_wr, 0);
        chk("rst_ack",  rq_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_th",   rrq_th, 0);
        chk("rst_addr", rrq_addr, 0);
        chk("rst_arg",  rrq_arg, 0);
        nrst = 1'b1;
        tick();

        // ---------------- T1 single thread, credit limit 4 ----------------
        rrq_rdy = 1'b1; rq_vld = 8'h04; acks = 0;
        for (int c = 0; c < 8; c++) begin
            set_addr(2, 37'h1000 + 37'(acks));
            #3;
            chk("t1_ack", rq_ack, (c < 4) ? 8'h04 : 8'h00);
            chk("t1_wr",  rrq_wr, (c >= 1 && c <= 4) ? 1 : 0);
            if (c >= 1 && c <= 4) begin
                chk("t1_th",   rrq_th, 2);
                chk("t1_addr", rrq_addr, 64'h1000 + 64'(c - 1));
            end
            if (rq_ack[2]) acks++;
            tick();
        end
        chk("t1_busy", busy, 1);
        rq_vld = 8'h00;
        drain("t1_rrs_rd", 2, 4);
        #3; chk("t1_idle", busy, 0); tick();

        // Bring the pointer back to NTHR-1 before the fairness run.
        reinit = 1'b1; tick(); reinit = 1'b0;

        // ---------------- T2 fairness 0,3,7 ----------------
        seq3 = '{0, 3, 7};
        foreach (cnt[i]) cnt[i] = 0;
        rq_vld = 8'h89; prev_wr = 1'b0; prev_th = '0;
        for (int c = 0; c < 9; c++) begin
            rrs_vld = prev_wr; rrs_th = prev_th; rs_rd = 8'hff;
            #3;
            chk("t2_ack", rq_ack, 64'(1 << seq3[c % 3]));
            if (c >= 1) begin
                chk("t2_wr", rrq_wr, 1);
                chk("t2_th", rrq_th, 64'(seq3[(c - 1) % 3]));
            end
            prev_wr = rrq_wr; prev_th = rrq_th;
            if (rrq_wr) cnt[rrq_th]++;
            tick();
        end
        rq_vld = 8'h00;
        for (int c = 0; c < 4; c++) begin
            rrs_vld = prev_wr; rrs_th = prev_th; rs_rd = 8'hff;
            #3;
            prev_wr = rrq_wr; prev_th = rrq_th;
            if (rrq_wr) cnt[rrq_th]++;
            tick();
        end
        rrs_vld = 1'b0; rs_rd = 8'h00;
        #3;
        chk("t2_cnt0", 64'(cnt[0]), 3);
        chk("t2_cnt3", 64'(cnt[3]), 3);
        chk("t2_cnt7", 64'(cnt[7]), 3);
        chk("t2_busy", busy, 0);
        tick();

        // ---------------- T3 LSU backpressure ----------------
        rrq_rdy = 1'b0; rq_vld = 8'h22; rq_arg = 8'h20;
        set_addr(1, 37'h111); set_addr(5, 37'h555);
        nack = 0; drop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (drop) rq_vld[1] = 1'b0;
            #3;
            if (c == 0) chk("t3_ack0", rq_ack, 8'h02);
            if (rq_ack != 0) nack++;
            chk("t3_wr", rrq_wr, 0);
            drop = rq_ack[1];
            tick();
        end
        chk("t3_nack", 64'(nack), 1);
        chk("t3_stg_th", rrq_th, 1);
        rrq_rdy = 1'b1;
        #3;
        chk("t3_wr1",   rrq_wr, 1);
        chk("t3_th1",   rrq_th, 1);
        chk("t3_addr1", rrq_addr, 64'h111);
        chk("t3_ack5",  rq_ack, 8'h20);
        tick();
        rq_vld = 8'h00;
        #3;
        chk("t3_wr5",   rrq_wr, 1);
        chk("t3_th5",   rrq_th, 5);
        chk("t3_addr5", rrq_addr, 64'h555);
        chk("t3_arg5",  rrq_arg, 1);
        tick();
        #3; chk("t3_wr_end", rrq_wr, 0);
        tick();
        rq_arg = 8'h00;
        drain("t3_rrs1", 1, 1);
        drain("t3_rrs5", 5, 1);
        #3; chk("t3_busy", busy, 0); tick();

        // ---------------- T4 credit return ----------------
        rq_vld = 8'h10; acks = 0;
        for (int c = 0; c < 6; c++) begin
            set_addr(4, 37'h4000 + 37'(acks));
            #3;
            chk("t4_ack", rq_ack, (c < 4) ? 8'h10 : 8'h00);
            chk("t4_wr",  rrq_wr, (c >= 1 && c <= 4) ? 1 : 0);
            if (rq_ack[4]) acks++;
            tick();
        end
        rrs_vld = 1'b1; rrs_th = 3'd4; rs_rd = 8'hff;   // pop one: 4 -> 3
        #3;
        chk("t4_pop",      rrs_rd, 1);
        chk("t4_pop_ack",  rq_ack, 0);
        tick();
        rrs_vld = 1'b0;
        #3; chk("t4_regrant", rq_ack, 8'h10); tick();
        rrs_vld = 1'b1;                                  // inc and dec together
        #3;
        chk("t4_sim_wr",  rrq_wr, 1);
        chk("t4_sim_rd",  rrs_rd, 1);
        chk("t4_sim_ack", rq_ack, 0);
        tick();
        rrs_vld = 1'b0;
        #3; chk("t4_keep_ack", rq_ack, 8'h10); tick();
        #3;
        chk("t4_last_wr",  rrq_wr, 1);
        chk("t4_full_ack", rq_ack, 0);
        tick();
        rq_vld = 8'h00;
        drain("t4_rrs", 4, 4);
        #3; chk("t4_busy", busy, 0); tick();

        // ---------------- T5 response routing ----------------
        rrs_vld = 1'b1; rrs_th = 3'd6; rrs_arg = 1'b1;
        rrs_data = 64'haabbccdd00000001; rs_rd = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("t5_rs_vld",  rs_vld, 8'h40);
            chk("t5_rrs_rd0", rrs_rd, 0);
            chk("t5_data",    rs_data, 64'haabbccdd00000001);
            chk("t5_arg",     rs_arg, 1);
            tick();
        end
        rs_rd = 8'hbf;
        #3; chk("t5_other_rd", rrs_rd, 0); tick();
        rs_rd = 8'h40;
        #3; chk("t5_rrs_rd1", rrs_rd, 1); tick();
        rrs_vld = 1'b0; rs_rd = 8'h00; rrs_arg = 1'b0;
        #3;
        chk("t5_rs_idle", rs_vld, 0);
        chk("t5_busy",    busy, 0);
        tick();

        // ---------------- T6 reinit mid-traffic ----------------
        rq_vld = 8'h07; drop_mask = 8'h00;
        foreach (n_ack_th[i]) n_ack_th[i] = 0;
        for (int c = 0; c < 7; c++) begin
            rq_vld = rq_vld & ~drop_mask;
            #3;
            chk("t6_ack", rq_ack, (c < 6) ? 64'(1 << (c % 3)) : 64'h0);
            if (c >= 1) begin
                chk("t6_wr", rrq_wr, 1);
                chk("t6_th", rrq_th, 64'((c - 1) % 3));
            end
            for (int t = 0; t < 8; t++) begin
                if (rq_ack[t]) begin
                    n_ack_th[t]++;
                    if (n_ack_th[t] == 2) drop_mask[t] = 1'b1;
                end
            end
            tick();
        end
        rq_vld = 8'h08; set_addr(3, 37'h333);
        #3; chk("t6_ack3", rq_ack, 8'h08); tick();
        rq_vld = 8'h20; reinit = 1'b1;
        #3;
        chk("t6_ri_wr",   rrq_wr, 0);
        chk("t6_ri_ack",  rq_ack, 0);
        chk("t6_ri_busy", busy, 1);
        tick();
        reinit = 1'b0; rq_vld = 8'h00;
        #3;
        chk("t6_post_busy", busy, 0);
        chk("t6_post_wr",   rrq_wr, 0);
        tick();
        for (int i = 0; i < 6; i++) drain("t6_late_rd", i % 3, 1);
        #3; chk("t6_late_busy", busy, 0); tick();
        rq_vld = 8'h21;
        #3; chk("t6_restart_ack", rq_ack, 8'h01); tick();
        rq_vld = 8'h00;
        #3;
        chk("t6_restart_wr", rrq_wr, 1);
        chk("t6_restart_th", rrq_th, 0);
        tick();
        drain("t6_end_rd", 0, 1);
        #3; chk("t6_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_vxe_vpu_rrq_arb
